// File: rtl/lfsr_rr_sched_pkg.sv
// Shared types and the LFSR step function for the round-robin LFSR scheduler.
// Optional statistics counter is enabled by defining LFSR_SCHED_STATS_EN.
package lfsr_rr_sched_pkg;

  localparam int unsigned       LFSR_W      = 16;
  localparam logic [LFSR_W-1:0] LFSR_LOCKUP = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

  // XNOR taps 16,15,13,4; the all-ones state maps to itself and must never be loaded.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[14:0], s[15] ~^ s[14] ~^ s[12] ~^ s[3]};
  endfunction

endpackage

// File: rtl/lfsr_rr_sched_if.sv
// Requester-side bundle of the LFSR scheduler; words_issued exists only when
// LFSR_SCHED_STATS_EN is defined.
interface lfsr_rr_sched_if #(
  parameter int unsigned NREQ = 4
);
  import lfsr_rr_sched_pkg::*;

  logic              seed_load;
  logic [LFSR_W-1:0] seed;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   gnt;
  logic              rnd_valid;
  logic [LFSR_W-1:0] rnd_data;
  logic              busy;
`ifdef LFSR_SCHED_STATS_EN
  logic [15:0]       words_issued;

  modport master (output seed_load, seed, req,
                  input  gnt, rnd_valid, rnd_data, busy, words_issued);
  modport slave  (input  seed_load, seed, req,
                  output gnt, rnd_valid, rnd_data, busy, words_issued);
`else
  modport master (output seed_load, seed, req,
                  input  gnt, rnd_valid, rnd_data, busy);
  modport slave  (input  seed_load, seed, req,
                  output gnt, rnd_valid, rnd_data, busy);
`endif

endinterface

// File: rtl/lfsr_rr_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module rr_arbiter #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IdxW-1:0] i_ptr,
  output logic [NREQ-1:0] o_pick,
  output logic [IdxW-1:0] o_idx,
  output logic            o_valid
);

  always_comb begin
    o_pick  = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!o_valid && i_req[(32'(i_ptr) + k) % NREQ]) begin
        o_valid = 1'b1;
        o_idx   = IdxW'((32'(i_ptr) + k) % NREQ);
      end
    end
    if (o_valid) o_pick = NREQ'(1) << o_idx;
  end

endmodule

// File: rtl/lfsr_rr_sched.sv
// Shares one 16-bit XNOR LFSR among NREQ requesters; each grant yields STEPS shifts.
// Define LFSR_SCHED_STATS_EN to add the saturating words_issued counter.
module lfsr_rr_sched
  import lfsr_rr_sched_pkg::*;
#(
  parameter int unsigned       NREQ         = 4,
  parameter int unsigned       STEPS        = 16,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = 16'h965A
) (
  input logic             i_clk,
  input logic             i_rst_n,
  lfsr_rr_sched_if.slave  io_bus
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_t            r_state;
  logic [LFSR_W-1:0] r_lfsr;
  logic [IdxW-1:0]   r_ptr;
  logic [IdxW-1:0]   r_winner;
  logic [CntW-1:0]   r_cnt;
  logic [NREQ-1:0]   r_gnt;
  logic              r_rnd_valid;
  logic [LFSR_W-1:0] r_rnd_data;
  logic              r_busy;
`ifdef LFSR_SCHED_STATS_EN
  logic [15:0]       r_words_issued;
`endif

  logic [NREQ-1:0]   w_pick;
  logic [IdxW-1:0]   w_pick_idx;
  logic              w_any;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .i_req   (io_bus.req),
    .i_ptr   (r_ptr),
    .o_pick  (w_pick),
    .o_idx   (w_pick_idx),
    .o_valid (w_any)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_lfsr         <= DEFAULT_SEED;
      r_ptr          <= '0;
      r_winner       <= '0;
      r_cnt          <= '0;
      r_gnt          <= '0;
      r_rnd_valid    <= 1'b0;
      r_rnd_data     <= '0;
      r_busy         <= 1'b0;
`ifdef LFSR_SCHED_STATS_EN
      r_words_issued <= '0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (io_bus.seed_load) begin
            r_lfsr <= (io_bus.seed == LFSR_LOCKUP) ? DEFAULT_SEED : io_bus.seed;
`ifdef LFSR_SCHED_STATS_EN
            r_words_issued <= '0;
`endif
          end else if (w_any) begin
            r_winner <= w_pick_idx;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_lfsr <= lfsr_next(r_lfsr);
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CntW'(STEPS - 1)) begin
            // Outputs are loaded here so they are registered while in OUT.
            r_rnd_valid <= 1'b1;
            r_rnd_data  <= lfsr_next(r_lfsr);
            r_gnt       <= NREQ'(1) << r_winner;
            r_state     <= OUT;
          end
        end
        OUT: begin
          r_rnd_valid <= 1'b0;
          r_rnd_data  <= '0;
          r_gnt       <= '0;
          r_busy      <= 1'b0;
          r_ptr       <= (r_winner == IdxW'(NREQ - 1)) ? '0 : r_winner + 1'b1;
          r_state     <= IDLE;
`ifdef LFSR_SCHED_STATS_EN
          if (r_words_issued != 16'hFFFF) r_words_issued <= r_words_issued + 1'b1;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.gnt       = r_gnt;
  assign io_bus.rnd_valid = r_rnd_valid;
  assign io_bus.rnd_data  = r_rnd_data;
  assign io_bus.busy      = r_busy;
`ifdef LFSR_SCHED_STATS_EN
  assign io_bus.words_issued = r_words_issued;
`endif

endmodule
